// File: rtl/hv_cmd_pkg.sv
// Shared definitions for the command scheduler: queue status codes, CDB opcodes,
// CDB field layout and the scheduler state encoding.
package hv_cmd_pkg;

    typedef enum logic [7:0] {
        ST_FREE      = 8'd0,
        ST_INSERTED  = 8'd1,
        ST_CKS_ERROR = 8'd2,
        ST_READY     = 8'd3,
        ST_Q2D       = 8'd4,
        ST_X2M       = 8'd5,
        ST_DONE      = 8'd6,
        ST_QUERIED   = 8'd7,
        ST_Q2D_ERROR = 8'd8
    } hv_status_t;

    typedef enum logic [7:0] {
        OP_READ  = 8'h01,
        OP_WRITE = 8'h02
    } hv_opcode_t;

    localparam int CDB_BEATS      = 4;
    localparam int CDB_OPCODE_LSB = 0;
    localparam int CDB_TAG_LSB    = 8;
    localparam int CDB_INDEX_LSB  = 16;
    localparam int CDB_STATUS_LSB = 24;
    localparam int CDB_LBA_LSB    = 64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_COLLECT = 3'd2,
        S_DECODE  = 3'd3,
        S_ALLOC   = 3'd4,
        S_ISSUE   = 3'd5
    } sched_state_t;

    function automatic logic opcode_ok(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/hv_tbm_alloc.sv
// TBM slot allocator: free bitmap, lowest-free priority encoder and the
// per-slot queue-index table used to match completions back to slots.
module hv_tbm_alloc #(
    parameter int NUM_TBM = 8,
    parameter int SLOT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_alloc,
    input  logic [7:0]        i_alloc_index,
    input  logic              i_cpl_valid,
    input  logic [7:0]        i_cpl_index,
    output logic              o_any_free,
    output logic [SLOT_W-1:0] o_free_slot,
    output logic              o_cpl_hit,
    output logic              o_any_used
);
    logic [NUM_TBM-1:0] r_used;
    logic [7:0]         r_slot_index [NUM_TBM];
    logic [NUM_TBM-1:0] w_free_mask;
    logic [NUM_TBM-1:0] w_alloc_mask;

    always_comb begin
        o_free_slot = '0;
        for (int i = NUM_TBM - 1; i >= 0; i--) begin
            if (!r_used[i]) o_free_slot = SLOT_W'(i);
        end
    end

    always_comb begin
        w_free_mask = '0;
        for (int i = 0; i < NUM_TBM; i++) begin
            w_free_mask[i] = i_cpl_valid && r_used[i] && (r_slot_index[i] == i_cpl_index);
        end
    end

    assign w_alloc_mask = i_alloc ? (NUM_TBM'(1) << o_free_slot) : '0;
    assign o_any_free   = ~&r_used;
    assign o_any_used   = |r_used;
    assign o_cpl_hit    = |w_free_mask;

    // Free and alloc land on the same edge; the encoder only ever sees the pre-free bitmap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_used <= '0;
            for (int i = 0; i < NUM_TBM; i++) r_slot_index[i] <= '0;
        end else begin
            r_used <= (r_used & ~w_free_mask) | w_alloc_mask;
            for (int i = 0; i < NUM_TBM; i++) begin
                if (w_alloc_mask[i]) r_slot_index[i] <= i_alloc_index;
            end
        end
    end

endmodule

// File: rtl/hv_cmd_scheduler.sv
// Command-queue scheduler: fetches a CDB, decodes it, claims a TBM slot,
// dispatches to the flash back-end and writes status transitions back.
// state   | meaning
// IDLE    | wait for a queued command and a free TBM slot
// REQ     | one-cycle fetch request
// COLLECT | latch the four CDB beats
// DECODE  | drop CDBs with checksum error or unknown opcode
// ALLOC   | claim lowest free slot, write its TBM address back
// ISSUE   | hold the back-end request until accepted
module hv_cmd_scheduler
    import hv_cmd_pkg::*;
#(
    parameter int          CMD_IO_WIDTH  = 64,
    parameter int          NUM_TBM       = 8,
    parameter logic [31:0] TBM_BASE      = 32'h0000_0000,
    parameter logic [31:0] TBM_SLOT_SIZE = 32'h0000_1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cq_cout_ready,
    output logic                    cmd_request,
    input  logic                    cmd_oe,
    input  logic [CMD_IO_WIDTH-1:0] cmd_in,
    output logic [7:0]              op_index,
    output logic [7:0]              cmd_op_status,
    output logic                    tbm_ie,
    output logic [7:0]              tbm_index,
    output logic [31:0]             tbm_address,
    output logic                    be_valid,
    input  logic                    be_ready,
    output logic [7:0]              be_index,
    output logic [7:0]              be_opcode,
    output logic [31:0]             be_lba,
    output logic [31:0]             be_tbm_addr,
    input  logic                    cpl_valid,
    input  logic [7:0]              cpl_index,
    input  logic                    cpl_error,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);
    localparam int SLOT_W = (NUM_TBM > 1) ? $clog2(NUM_TBM) : 1;

    sched_state_t                           r_state;
    sched_state_t                           w_next;
    logic [CDB_BEATS-1:0][CMD_IO_WIDTH-1:0] r_cdb;
    logic [1:0]                             r_beat;
    logic [31:0]                            r_tbm_addr;
    logic [7:0]                             r_drop_cnt;
    logic [7:0]                             r_op_index;
    logic [7:0]                             r_op_status;
    logic                                   r_pend_vld;
    logic [7:0]                             r_pend_idx;

    logic [CDB_BEATS*CMD_IO_WIDTH-1:0]      w_cdb;
    logic [7:0]                             w_opcode;
    logic [7:0]                             w_index;
    logic [7:0]                             w_status;
    logic [31:0]                            w_lba;
    logic [31:0]                            w_tbm_addr;
    logic                                   w_cdb_bad;
    logic                                   w_any_free;
    logic                                   w_any_used;
    logic                                   w_cpl_hit;
    logic                                   w_alloc;
    logic                                   w_x2m_fire;
    logic [SLOT_W-1:0]                      w_free_slot;
    logic                                   w_unused;

    assign w_cdb      = r_cdb;
    assign w_opcode   = w_cdb[CDB_OPCODE_LSB +: 8];
    assign w_index    = w_cdb[CDB_INDEX_LSB +: 8];
    assign w_status   = w_cdb[CDB_STATUS_LSB +: 8];
    assign w_lba      = w_cdb[CDB_LBA_LSB +: 32];
    assign w_cdb_bad  = (w_status == ST_CKS_ERROR) || !opcode_ok(w_opcode);
    assign w_tbm_addr = TBM_BASE + TBM_SLOT_SIZE * 32'(w_free_slot);
    assign w_alloc    = (r_state == S_ALLOC);
    assign w_x2m_fire = (r_state == S_ISSUE) && be_ready;
    assign w_unused   = ^{w_cdb[CDB_BEATS*CMD_IO_WIDTH-1:CDB_LBA_LSB+32],
                          w_cdb[CDB_LBA_LSB-1:CDB_STATUS_LSB+8],
                          w_cdb[CDB_TAG_LSB +: 8]};

    hv_tbm_alloc #(
        .NUM_TBM (NUM_TBM),
        .SLOT_W  (SLOT_W)
    ) u_alloc (
        .clk           (clk),
        .reset         (reset),
        .i_alloc       (w_alloc),
        .i_alloc_index (w_index),
        .i_cpl_valid   (cpl_valid),
        .i_cpl_index   (cpl_index),
        .o_any_free    (w_any_free),
        .o_free_slot   (w_free_slot),
        .o_cpl_hit     (w_cpl_hit),
        .o_any_used    (w_any_used)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (cq_cout_ready && w_any_free) w_next = S_REQ;
            S_REQ:     w_next = S_COLLECT;
            S_COLLECT: if (cmd_oe && r_beat == 2'd3) w_next = S_DECODE;
            S_DECODE:  w_next = w_cdb_bad ? S_IDLE : S_ALLOC;
            S_ALLOC:   w_next = S_ISSUE;
            S_ISSUE:   if (be_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_request = (r_state == S_REQ);
        tbm_ie      = 1'b0;
        tbm_index   = '0;
        tbm_address = '0;
        be_valid    = 1'b0;
        be_index    = '0;
        be_opcode   = '0;
        be_lba      = '0;
        be_tbm_addr = '0;
        if (r_state == S_ALLOC) begin
            tbm_ie      = 1'b1;
            tbm_index   = w_index;
            tbm_address = w_tbm_addr;
        end
        if (r_state == S_ISSUE) begin
            be_valid    = 1'b1;
            be_index    = w_index;
            be_opcode   = w_opcode;
            be_lba      = w_lba;
            be_tbm_addr = r_tbm_addr;
        end
    end

    assign op_index      = r_op_index;
    assign cmd_op_status = r_op_status;
    assign drop_cnt      = r_drop_cnt;
    assign busy          = (r_state != S_IDLE) || w_any_used;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cdb      <= '0;
            r_beat     <= '0;
            r_tbm_addr <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (r_state == S_REQ) begin
                r_beat <= '0;
            end else if (r_state == S_COLLECT && cmd_oe) begin
                r_cdb[r_beat] <= cmd_in;
                r_beat        <= r_beat + 2'd1;
            end
            if (r_state == S_DECODE && w_cdb_bad && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_alloc)
                r_tbm_addr <= w_tbm_addr;
        end
    end

    // Completion owns the status port; a colliding X2M waits one cycle in the pending slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_index  <= '0;
            r_op_status <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_idx  <= '0;
        end else begin
            r_op_index  <= '0;
            r_op_status <= '0;
            if (w_cpl_hit) begin
                r_op_index  <= cpl_index;
                r_op_status <= cpl_error ? ST_Q2D_ERROR : ST_DONE;
                if (w_x2m_fire) begin
                    r_pend_vld <= 1'b1;
                    r_pend_idx <= w_index;
                end
            end else if (r_pend_vld) begin
                r_op_index  <= r_pend_idx;
                r_op_status <= ST_X2M;
                r_pend_vld  <= w_x2m_fire;
                if (w_x2m_fire) r_pend_idx <= w_index;
            end else if (w_x2m_fire) begin
                r_op_index  <= w_index;
                r_op_status <= ST_X2M;
            end
        end
    end

endmodule
